// File: rtl/passcode_controller_if.sv
// Keypad-side bundle for the passcode controller.
// master drives keys, slave is the controller.
interface passcode_controller_if #(
  parameter int CODE_LEN = 4
);
  localparam int DW = $clog2(CODE_LEN + 1);

  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ack;
  logic [DW-1:0] digit_count;
  logic          unlocked;
  logic          prog_mode;
  logic          err;
  logic          locked_out;

  modport master (
    output key_code, key_valid,
    input  key_ack, digit_count, unlocked,
    input  prog_mode, err, locked_out
  );

  modport slave (
    input  key_code, key_valid,
    output key_ack, digit_count, unlocked,
    output prog_mode, err, locked_out
  );
endinterface

// File: rtl/passcode_controller.sv
// Passcode lock: debounces keypad presses, collects digits,
// checks against a stored code, handles lockout and reprogramming.
module passcode_controller #(
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int UNLOCK_CYCLES = 50000000,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input logic clk,
  input logic rst,
  passcode_controller_if.slave bus
);
  localparam int CW = CODE_LEN * 4;
  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES)
                      ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  logic          pressed;
  logic [BW-1:0] stable_cnt;
  logic [3:0]    ev_code;
  logic          ack;

  state_t        state;
  logic [CW-1:0] entry;
  logic [CW-1:0] stored;
  logic [DW-1:0] count;
  logic [FW-1:0] fails;
  logic [TW-1:0] timer;
  logic          unlocked_q;
  logic          prog_q;
  logic          err_q;
  logic          lock_q;

  logic is_digit;
  logic is_prog;
  logic is_enter;
  logic is_clear;
  logic full;
  logic expired;

  assign is_digit = ack && (ev_code <= 4'h9);
  assign is_prog  = ack && (ev_code == 4'hA);
  assign is_enter = ack && (ev_code == 4'hE);
  assign is_clear = ack && (ev_code == 4'hF);
  assign full     = (count == DW'(CODE_LEN));
  assign expired  = (timer <= TW'(1));

  // Debounce key_valid; one key_ack and code latch per press
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed    <= 1'b0;
      stable_cnt <= '0;
      ev_code    <= '0;
      ack        <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (bus.key_valid == pressed) begin
        stable_cnt <= '0;
      end else if (stable_cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
        stable_cnt <= '0;
        pressed    <= ~pressed;
        if (!pressed) begin
          ack     <= 1'b1;
          ev_code <= bus.key_code;
        end
      end else begin
        stable_cnt <= stable_cnt + BW'(1);
      end
    end
  end

  // Lock FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ENTRY;
      entry      <= '0;
      stored     <= DEFAULT_CODE;
      count      <= '0;
      fails      <= '0;
      timer      <= '0;
      unlocked_q <= 1'b0;
      prog_q     <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        S_ENTRY, S_PROG: begin
          unique case (1'b1)
            is_digit: begin
              if (!full) begin
                entry <= (entry << 4) | CW'(ev_code);
                count <= count + DW'(1);
              end
            end
            is_clear: begin
              entry <= '0;
              count <= '0;
            end
            is_enter: begin
              if (state == S_ENTRY) begin
                state <= S_CHECK;
              end else begin
                if (full) stored <= entry;
                state  <= S_ENTRY;
                prog_q <= 1'b0;
                entry  <= '0;
                count  <= '0;
              end
            end
            default: ;
          endcase
        end
        S_CHECK: begin
          entry <= '0;
          count <= '0;
          if (full && (entry == stored)) begin
            state      <= S_OPEN;
            unlocked_q <= 1'b1;
            fails      <= '0;
            timer      <= TW'(UNLOCK_CYCLES);
          end else begin
            err_q <= 1'b1;
            fails <= fails + FW'(1);
            if (fails == FW'(MAX_TRIES - 1)) begin
              state  <= S_LOCKOUT;
              lock_q <= 1'b1;
              timer  <= TW'(LOCKOUT_CYCLES);
            end else begin
              state <= S_ENTRY;
            end
          end
        end
        S_OPEN: begin
          if (expired) begin
            state      <= S_ENTRY;
            unlocked_q <= 1'b0;
            timer      <= '0;
          end else begin
            timer <= timer - TW'(1);
            if (is_enter) begin
              state      <= S_ENTRY;
              unlocked_q <= 1'b0;
              timer      <= '0;
            end else if (is_prog) begin
              state      <= S_PROG;
              unlocked_q <= 1'b0;
              prog_q     <= 1'b1;
              entry      <= '0;
              count      <= '0;
              timer      <= '0;
            end
          end
        end
        S_LOCKOUT: begin
          if (expired) begin
            state  <= S_ENTRY;
            lock_q <= 1'b0;
            fails  <= '0;
            timer  <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

  assign bus.key_ack     = ack;
  assign bus.digit_count = count;
  assign bus.unlocked    = unlocked_q;
  assign bus.prog_mode   = prog_q;
  assign bus.err         = err_q;
  assign bus.locked_out  = lock_q;
endmodule

// File: tb/tb_passcode_controller.sv
// Bench for passcode_controller: directed and random key sequences
// checked every cycle against a timestamp-based lock model.
module tb_passcode_controller;
  localparam int LEN = 4;
  localparam int DEB = 2;
  localparam int UNL = 10;
  localparam int LCK = 20;
  localparam int TRIES = 3;

  typedef enum {M_ENTRY, M_CHECK, M_OPEN, M_PROG, M_LOCK} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  passcode_controller_if #(.CODE_LEN(LEN)) bus ();

  passcode_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .UNLOCK_CYCLES(UNL),
    .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  mode_t mode = M_ENTRY;
  int    entry_q[$];
  int    code_q[$];
  int    fails_m = 0;
  int    open_end = 0;
  int    lock_end = 0;
  int    ack_cyc = -10;
  int    ev_k = 0;
  bit    exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h cycle %0d",
                tag, obs, exp, cyc);
  endtask

  function automatic bit same_code();
    if (entry_q.size() != code_q.size()) return 1'b0;
    foreach (entry_q[j]) if (entry_q[j] != code_q[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int c, input logic r);
    bit ev;
    exp_err = 1'b0;
    if (r) begin
      mode = M_ENTRY;
      entry_q.delete();
      code_q = '{1, 2, 3, 4};
      fails_m = 0;
      ack_cyc = -10;
      return;
    end
    ev = (c == ack_cyc + 1);
    case (mode)
      M_CHECK: begin
        if (entry_q.size() == LEN && same_code()) begin
          mode = M_OPEN;
          open_end = c + UNL;
          fails_m = 0;
        end else begin
          exp_err = 1'b1;
          fails_m++;
          if (fails_m == TRIES) begin
            mode = M_LOCK;
            lock_end = c + LCK;
          end else begin
            mode = M_ENTRY;
          end
        end
        entry_q.delete();
      end
      M_OPEN: begin
        if (c == open_end) mode = M_ENTRY;
        else if (ev && ev_k == 14) mode = M_ENTRY;
        else if (ev && ev_k == 10) begin
          mode = M_PROG;
          entry_q.delete();
        end
      end
      M_LOCK: begin
        if (c == lock_end) begin
          mode = M_ENTRY;
          fails_m = 0;
        end
      end
      default: begin
        if (ev) begin
          if (ev_k <= 9) begin
            if (entry_q.size() < LEN) entry_q.push_back(ev_k);
          end else if (ev_k == 15) begin
            entry_q.delete();
          end else if (ev_k == 14) begin
            if (mode == M_ENTRY) mode = M_CHECK;
            else begin
              if (entry_q.size() == LEN) code_q = entry_q;
              mode = M_ENTRY;
              entry_q.delete();
            end
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    cyc++;
    #1;
    model_step(cyc, r);
    chk("key_ack", 32'(bus.key_ack), 32'(cyc == ack_cyc));
    chk("unlocked", 32'(bus.unlocked), 32'(mode == M_OPEN));
    chk("prog_mode", 32'(bus.prog_mode), 32'(mode == M_PROG));
    chk("locked_out", 32'(bus.locked_out), 32'(mode == M_LOCK));
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("digit_count", 32'(bus.digit_count), 32'(entry_q.size()));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    bus.key_code = k;
    bus.key_valid = 1'b1;
    if (hold >= DEB) begin
      ack_cyc = cyc + DEB;
      ev_k = int'(k);
    end
    repeat (hold) tick();
    bus.key_valid = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic seq(input int keys[$], input int hold, input int rel);
    foreach (keys[j]) press(4'(keys[j]), hold, rel);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int cq[$];
  int sel;

  initial begin
    bus.key_code = 4'h0;
    bus.key_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    seq('{1, 2, 3, 4, 14}, 5, 5);
    idle(15);

    seq('{1, 2, 3, 5, 14}, 5, 5);
    idle(5);

    seq('{1, 2, 3, 4, 14}, 3, 3);
    idle(15);
    seq('{5, 5, 5, 5, 14}, 3, 3);
    seq('{0, 14}, 3, 3);
    seq('{7, 14}, 3, 3);
    seq('{1, 2, 3, 4, 14}, 2, 2);
    idle(30);
    seq('{1, 2, 3, 4, 14}, 3, 3);
    idle(15);

    seq('{1, 2, 15, 1, 2, 3, 4, 5, 14}, 3, 3);
    idle(15);

    seq('{1, 2, 3, 4, 14, 10}, 3, 3);
    seq('{9, 8, 7, 6, 14}, 3, 3);
    idle(3);
    seq('{1, 2, 3, 4, 14}, 3, 3);
    idle(5);
    seq('{9, 8, 7, 6, 14}, 3, 3);
    do_reset();
    idle(3);
    seq('{1, 2, 3, 4, 14}, 3, 3);
    idle(15);

    press(4'h3, 1, 5);
    press(4'h7, 40, 5);
    seq('{11, 12, 13, 15}, 3, 3);
    idle(3);

    seq('{1, 2, 3, 4, 14, 10, 1, 2, 14}, 3, 3);
    idle(5);
    seq('{1, 2, 3, 4, 14}, 3, 3);
    idle(15);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        cq = code_q;
        foreach (cq[j])
          press(4'(cq[j]), int'($urandom_range(2, 6)),
                int'($urandom_range(3, 6)));
        press(4'hE, int'($urandom_range(2, 6)),
              int'($urandom_range(3, 6)));
      end else if (sel == 1) begin
        press(4'($urandom_range(0, 15)), 1, int'($urandom_range(3, 6)));
      end else begin
        press(4'($urandom_range(0, 15)), int'($urandom_range(2, 8)),
              int'($urandom_range(3, 8)));
      end
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 25)));
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    idle(30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
